// File: rtl/serial_scan_ctrl.sv
// Serial scan controller: serializes a captured word MSB first and counts
// occurrences of a PAT_W-bit pattern in the bit stream, with selectable
// overlapping or non-overlapping detection.
module serial_scan_ctrl #(
    parameter int WORD_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] din,
    input  logic [PAT_W-1:0]  pat,
    input  logic              overlap,
    output logic              busy,
    output logic              done,
    output logic              sbit,
    output logic              z,
    output logic [CNT_W-1:0]  match_cnt
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int VC_W  = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_nxt;
    logic [WORD_W-1:0]  sreg;
    logic [PAT_W-1:0]   pat_q;
    logic               ovl_q;
    logic [PAT_W-1:0]   win, win_nxt;
    logic [VC_W-1:0]    vcnt, vcnt_nxt;
    logic [IDX_W-1:0]   idx;
    logic               hit;

    // State register; reset returns to IDLE, aborting any word in flight.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and Moore outputs; sbit is the MSB of the shifting copy.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        sbit      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                sbit = sreg[WORD_W-1];
                if (idx == IDX_W'(WORD_W - 1)) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Incoming window and saturating valid count; a hit needs a full window.
    always_comb begin
        win_nxt  = PAT_W'({win, sbit});
        vcnt_nxt = (vcnt == VC_W'(PAT_W)) ? vcnt : vcnt + VC_W'(1);
        hit      = (state == SHIFT) && (win_nxt == pat_q) && (vcnt_nxt == VC_W'(PAT_W));
    end

    // Datapath: capture on accepted start, shift/detect in SHIFT, drop z after.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sreg      <= '0;
            pat_q     <= '0;
            ovl_q     <= 1'b0;
            win       <= '0;
            vcnt      <= '0;
            idx       <= '0;
            z         <= 1'b0;
            match_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg      <= din;
                        pat_q     <= pat;
                        ovl_q     <= overlap;
                        win       <= '0;
                        vcnt      <= '0;
                        idx       <= '0;
                        z         <= 1'b0;
                        match_cnt <= '0;
                    end
                end
                SHIFT: begin
                    sreg <= sreg << 1;
                    win  <= win_nxt;
                    idx  <= idx + IDX_W'(1);
                    if (hit) begin
                        z    <= 1'b1;
                        // Non-overlapping mode forces PAT_W fresh bits before the next hit.
                        vcnt <= ovl_q ? vcnt_nxt : '0;
                        if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
                    end else begin
                        z    <= 1'b0;
                        vcnt <= vcnt_nxt;
                    end
                end
                DONE: begin
                    z <= 1'b0;
                end
                default: begin
                    z <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_scan_ctrl.sv
// Directed bench for serial_scan_ctrl: pattern counting, overlap modes,
// latency, start handling, mid-scan input changes and reset abort.
// A second instance with a 2-bit counter exercises match_cnt saturation.
module tb_serial_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic [3:0] pat;
    logic       overlap;
    logic       busy, done, sbit, z;
    logic [3:0] match_cnt;
    logic       s_busy, s_done, s_sbit, s_z;
    logic [1:0] s_match_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    serial_scan_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .pat(pat), .overlap(overlap),
        .busy(busy), .done(done), .sbit(sbit), .z(z), .match_cnt(match_cnt)
    );

    serial_scan_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .din(din), .pat(pat), .overlap(overlap),
        .busy(s_busy), .done(s_done), .sbit(s_sbit), .z(s_z), .match_cnt(s_match_cnt)
    );

    // One clock edge; inputs are then driven and outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scan one word from IDLE and check serial bits, z pulses, latency and count.
    task automatic run_word(input string name, input logic [7:0] d, input logic [3:0] p,
                            input logic o, input int exp_cnt, input logic [7:0] exp_zm,
                            input bit scramble);
        logic [7:0] sb;
        logic [7:0] zm;
        int         exp_sat;
        exp_sat = (exp_cnt > 3) ? 3 : exp_cnt;
        din = d; pat = p; overlap = o; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sb[7-k] = sbit;
            if (scramble && k == 2) begin
                din = ~d; pat = ~p; overlap = ~o;
            end
            step();
            zm[k] = z;
        end
        n_checks++; if (sb !== d) begin n_fails++; $display("FAIL %s sbit seq: got %b exp %b", name, sb, d); end
        n_checks++; if (zm !== exp_zm) begin n_fails++; $display("FAIL %s z pulses: got %b exp %b", name, zm, exp_zm); end
        n_checks++; if (done !== 1'b1) begin n_fails++; $display("FAIL %s done at edge 9: got %b exp 1", name, done); end
        n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL %s busy in DONE: got %b exp 1", name, busy); end
        n_checks++; if (match_cnt !== 4'(exp_cnt)) begin n_fails++; $display("FAIL %s match_cnt: got %0d exp %0d", name, match_cnt, exp_cnt); end
        n_checks++; if (s_match_cnt !== 2'(exp_sat)) begin n_fails++; $display("FAIL %s sat match_cnt: got %0d exp %0d", name, s_match_cnt, exp_sat); end
        step();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fails++; $display("FAIL %s idle after done: got done=%b busy=%b exp 0/0", name, done, busy); end
        n_checks++; if (match_cnt !== 4'(exp_cnt)) begin n_fails++; $display("FAIL %s match_cnt hold: got %0d exp %0d", name, match_cnt, exp_cnt); end
        din = d; pat = p; overlap = o;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; din = '0; pat = '0; overlap = 1'b0;
        step(); step();
        rst = 1'b1;
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset busy: got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL reset done: got %b exp 0", done); end
        n_checks++; if (sbit !== 1'b0) begin n_fails++; $display("FAIL reset sbit: got %b exp 0", sbit); end
        n_checks++; if (z !== 1'b0) begin n_fails++; $display("FAIL reset z: got %b exp 0", z); end
        n_checks++; if (match_cnt !== 4'd0) begin n_fails++; $display("FAIL reset match_cnt: got %0d exp 0", match_cnt); end
        step();
    endtask

    task automatic test_patterns();
        run_word("aa_ovl",   8'b1010_1010, 4'b1010, 1'b1, 3, 8'b1010_1000, 1'b0);
        run_word("aa_novl",  8'b1010_1010, 4'b1010, 1'b0, 2, 8'b1000_1000, 1'b0);
        run_word("zero_ovl", 8'h00,        4'b0000, 1'b1, 5, 8'b1111_1000, 1'b0);
        run_word("zero_novl",8'h00,        4'b0000, 1'b0, 2, 8'b1000_1000, 1'b0);
        run_word("ones",     8'hFF,        4'b0000, 1'b1, 0, 8'b0000_0000, 1'b0);
        run_word("last_bit", 8'b0111_0101, 4'b0101, 1'b1, 1, 8'b1000_0000, 1'b0);
    endtask

    task automatic test_mid_change();
        run_word("mid_change", 8'b1010_1010, 4'b1010, 1'b1, 3, 8'b1010_1000, 1'b1);
    endtask

    task automatic test_back_to_back();
        din = 8'b1010_1010; pat = 4'b1010; overlap = 1'b1; start = 1'b1;
        step();
        for (int i = 1; i <= 18; i++) begin
            step();
            if (i == 8) begin
                n_checks++; if (done !== 1'b1) begin n_fails++; $display("FAIL b2b first done: got %b exp 1", done); end
            end
            if (i == 9) begin
                n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL b2b start in DONE ignored: busy got %b exp 0", busy); end
            end
            if (i == 10) begin
                n_checks++; if (busy !== 1'b1 || sbit !== 1'b1) begin n_fails++; $display("FAIL b2b second accept: busy=%b sbit=%b exp 1/1", busy, sbit); end
                n_checks++; if (match_cnt !== 4'd0) begin n_fails++; $display("FAIL b2b count cleared: got %0d exp 0", match_cnt); end
            end
        end
        n_checks++; if (done !== 1'b1 || match_cnt !== 4'd3) begin n_fails++; $display("FAIL b2b second done: done=%b cnt=%0d exp 1/3", done, match_cnt); end
        start = 1'b0;
        step();
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL b2b idle after release: busy got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        din = 8'b1010_1010; pat = 4'b1010; overlap = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        n_checks++; if (match_cnt !== 4'd1 || busy !== 1'b1) begin n_fails++; $display("FAIL rst_mid pre: cnt=%0d busy=%b exp 1/1", match_cnt, busy); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        n_checks++; if (busy !== 1'b0 || match_cnt !== 4'd0 || done !== 1'b0 || z !== 1'b0) begin
            n_fails++; $display("FAIL rst_mid after: busy=%b cnt=%0d done=%b z=%b exp 0/0/0/0", busy, match_cnt, done, z);
        end
        seen_done = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        n_checks++; if (seen_done != 0) begin n_fails++; $display("FAIL rst_mid no done: got %0d active cycles exp 0", seen_done); end
        run_word("after_rst", 8'b1010_1010, 4'b1010, 1'b1, 3, 8'b1010_1000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_mid_change();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/serial_scan_ctrl.md
SERIAL_SCAN_CTRL -- requirements
Module: serial_scan_ctrl

Interface
REQ-001 Parameter WORD_W, 8, width of the parallel word to be scanned (WORD_W >= PAT_W) SHALL be supported.
REQ-002 Parameter PAT_W, 4, pattern length in bits SHALL be supported.
REQ-003 Parameter CNT_W, 4, match-counter width SHALL be supported.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-006 start  input  1  request to scan din; sampled only in IDLE.
REQ-007 din  input  WORD_W  word to serialize, MSB first.
REQ-008 pat  input  PAT_W  pattern to detect; pat[PAT_W-1] is the oldest bit.
REQ-009 overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 busy  output  1  high from accepted start until done inclusive.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 sbit  output  1  serial bit presented this cycle; 0 outside SHIFT.
REQ-013 z  output  1  Moore match flag, registered.
REQ-014 match_cnt  output  CNT_W  matches found in the current word.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE.
- IDLE->SHIFT on start=1.
- SHIFT->DONE after WORD_W bits.
- DONE->IDLE unconditionally.
REQ-016 At the edge accepting start, the block SHALL:
- capture din, pat and overlap into internal registers;
- clear the window, the valid-bit count, match_cnt and z;
- set bit index to 0 and busy to 1.
REQ-017 In SHIFT cycle k (k = 0..WORD_W-1), sbit SHALL equal captured din[WORD_W-1-k]; at the end of that cycle window <= {window[PAT_W-2:0], sbit}.
REQ-018 The valid-bit count SHALL increment per shifted bit, saturating at PAT_W.
- A match occurs at an edge when the incoming window value equals the captured pat and the count reaches PAT_W.
REQ-019 On a match, match_cnt SHALL increment at that same edge, saturating at 2^CNT_W-1 with no wrap.
- z SHALL be 1 for exactly the following cycle.
- z SHALL be 0 on every edge that is not a match.
REQ-020 Overlap handling after a match:
- overlap=1: the window and count SHALL be retained.
- overlap=0: the count SHALL be cleared, so the next match needs PAT_W fresh bits.
REQ-021 Inputs din, pat and overlap changing during SHIFT/DONE SHALL have no effect; only the captured copies are used.
REQ-022 The DONE state SHALL last one cycle.
- done=1 and busy=1 in that cycle.
- match_cnt is final in that cycle, including a match on the last bit, whose z is also visible in DONE.
REQ-023 start SHALL be ignored while busy=1, including the DONE cycle.
- A start presented in the IDLE cycle after DONE SHALL be accepted.
REQ-024 Latency SHALL be: start edge -> done high after WORD_W+1 edges; back-to-back words need WORD_W+2 cycles each.
REQ-025 match_cnt and z SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-026 When rst=0 at a clock edge, the block SHALL:
- set state to IDLE;
- set busy=0, done=0, sbit=0, z=0 and match_cnt=0;
- clear the window, valid count and bit index.
REQ-027 Reset SHALL override everything, including mid-SHIFT and DONE.
- No done pulse SHALL be produced for an aborted word.
- The first start after rst=1 SHALL begin a fresh scan.

Verification
REQ-028 din=8'b1010_1010, pat=4'b1010, overlap=1 -> z pulses after bits 3, 5 and 7; match_cnt=3 at done; done occurs 9 edges after start.
REQ-029 Same din and pat, overlap=0 -> z pulses after bits 3 and 7 only; match_cnt=2.
REQ-030 din=8'h00, pat=4'b0000 -> overlap=1 gives match_cnt=5; overlap=0 gives match_cnt=2. din=8'hFF, pat=4'b0000 gives match_cnt=0 and z never asserted.
REQ-031 start held high continuously -> a new word is accepted every 10 cycles; start during the DONE cycle is not accepted; din changed mid-SHIFT leaves the result unchanged.
REQ-032 rst=0 asserted during SHIFT bit 4 -> next cycle busy=0, match_cnt=0, no done; a subsequent start with 8'b1010_1010, overlap=1 yields match_cnt=3.
REQ-033 Sequence 0111_0101 with pat 0101, overlap=1 -> single match after bit 7; z=1 in the DONE cycle; match_cnt=1.
